video_scan_gen: RTL
===================

// Module: video_scan_gen
// PURPOSE
//  Raster scan source that drives the hcount/vcount inputs of the renderer (mega) and consumes its color.
//  Produces pixel coordinates, sync and data-enable, and delays sync/DE by the renderer latency so they
//  line up with the returned color. Sits between the pixel clock domain root and the HDMI/VGA encoder.
// PARAMETERS
//  H_ACTIVE   1280  visible pixels per line
//  H_FP       110   horizontal front porch (pixels)
//  H_SYNC     40    hsync width (pixels)
//  H_BP       220   horizontal back porch; H_TOTAL = sum of the four H_* = 1650
//  V_ACTIVE   720   visible lines
//  V_FP       5     vertical front porch (lines)
//  V_SYNC     5     vsync width (lines)
//  V_BP       20    vertical back porch; V_TOTAL = 750
//  PIPE_DEPTH 4     renderer latency in enabled pixel cycles (0..15); 0 = combinational renderer
// PORTS
//  clk_in         in   1   pixel clock
//  rst_in         in   1   asynchronous, active-low reset
//  pix_en_in      in   1   pixel advance enable; low = whole block holds state
//  color_in       in   8   renderer color, valid PIPE_DEPTH enabled cycles after its hcount/vcount
//  hcount_out     out  11  current pixel column (registered counter)
//  vcount_out     out  10  current line (registered counter)
//  active_out     out  1   hcount_out<H_ACTIVE && vcount_out<V_ACTIVE (undelayed)
//  new_frame_out  out  1   1-cycle pulse at start of vertical blank
//  frame_cnt_out  out  6   frame counter, wraps 63->0
//  hsync_out      out  1   aligned hsync, active-high
//  vsync_out      out  1   aligned vsync, active-high
//  de_out         out  1   aligned data enable
//  color_out      out  8   aligned color; 0 when de_out low
// BEHAVIOUR
//  - Reset (rst_in=0, no clock needed): all outputs 0, counters 0, delay line cleared.
//  - All state updates only on rising clk_in with pix_en_in=1; with pix_en_in=0 every register holds.
//  - hcount: +1 per enabled cycle; H_TOTAL-1 -> 0. vcount: +1 when hcount wraps; V_TOTAL-1 -> 0 with it.
//  - hsync_raw = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync_raw same on vcount with V_*.
//  - new_frame_out = 1 for exactly the cycle hcount==H_ACTIVE && vcount==V_ACTIVE (combinational from
//    counters); frame_cnt_out increments on the enabled clock edge that ends that cycle.
//  - Delay line: {hsync_raw,vsync_raw,active} shifted PIPE_DEPTH enabled stages, then one output register
//    stage that also captures color_in: color_out <= de_delayed ? color_in : 8'h00.
//  - Latency: hsync/vsync/de/color_out reflect counter value from PIPE_DEPTH+1 enabled cycles earlier.
//  - PIPE_DEPTH=0: delay line vanishes; only the output register remains (latency 1).
//  - Sizing: counters are full-width; H_TOTAL must fit in 11 bits and V_TOTAL in 10 bits (elaboration check).
//  - After reset release, the first PIPE_DEPTH+1 enabled cycles output de_out=0 and sync=0 (cleared line).
//  - Reset asserted mid-line: immediate return to (0,0), frame_cnt_out=0; no pulse on new_frame_out.
// STRUCTURE
//  - video_pkg: 720p timing localparams and a small test mode (16/2/2/2, 8/1/1/1); typedef struct
//    packed {logic hs, vs, de;} sync_t.
//  - Sub-module sync_delay #(DEPTH, WIDTH): enabled shift register with asynchronous active-low clear,
//    DEPTH=0 pass-through; instantiated once on sync_t.
//  - Top: the counters, decode, new_frame/frame counter, and the output register.
// TESTING (small mode: H 16/2/2/2 => H_TOTAL 22, V 8/1/1/1 => V_TOTAL 11, PIPE_DEPTH 4)
//  1. Release reset, pix_en=1, run 22 cycles -> hcount 0..21 then 0, vcount 0->1 on that wrap.
//  2. Per line -> hsync_raw high only at hcount 18,19; hsync_out high 5 cycles later, 2 cycles wide.
//  3. Run 2 frames (484 cycles) -> new_frame_out pulses exactly twice, at (16,8); frame_cnt_out 0->1->2.
//  4. Model renderer: color_in = hcount[7:0]+vcount[7:0] through a 4-stage pipe -> color_out equals value
//     of pixel from 5 cycles earlier when de_out=1; 0 otherwise; de_out high 16 of every 22 cycles, lines 0..7.
//  5. Drop pix_en_in for 10 cycles mid-line at hcount=7 -> every output frozen; resumes at hcount=8.
//  6. Assert rst_in between clock edges at (10,3) -> all outputs 0 before the next edge; restart from (0,0).

Source files
------------

// File: rtl/video_pkg.sv
// Raster timing constants and shared types for the scan generator.
// Holds 720p timing, a tiny test raster and the sync bundle layout.
package video_pkg;

    localparam int HD_H_ACTIVE = 1280;
    localparam int HD_H_FP     = 110;
    localparam int HD_H_SYNC   = 40;
    localparam int HD_H_BP     = 220;
    localparam int HD_V_ACTIVE = 720;
    localparam int HD_V_FP     = 5;
    localparam int HD_V_SYNC   = 5;
    localparam int HD_V_BP     = 20;

    localparam int TM_H_ACTIVE = 16;
    localparam int TM_H_FP     = 2;
    localparam int TM_H_SYNC   = 2;
    localparam int TM_H_BP     = 2;
    localparam int TM_V_ACTIVE = 8;
    localparam int TM_V_FP     = 1;
    localparam int TM_V_SYNC   = 1;
    localparam int TM_V_BP     = 1;

    localparam int PIPE_DEPTH_DEF = 4;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic int span_total(int a, int f, int s, int b);
        return a + f + s + b;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register with async active-low clear.
// DEPTH=0 collapses to a plain wire.
module sync_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused;
            assign unused = &{1'b0, clk, rst_n, en};
            assign q = d;
        end else begin : g_sr
            logic [DEPTH-1:0][WIDTH-1:0] sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (en) begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end
            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_scan_gen.sv
// Raster scan source: pixel counters, sync decode, frame counter,
// and sync/DE/color aligned to the renderer pipeline latency.
module video_scan_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = HD_H_ACTIVE,
    parameter int H_FP       = HD_H_FP,
    parameter int H_SYNC     = HD_H_SYNC,
    parameter int H_BP       = HD_H_BP,
    parameter int V_ACTIVE   = HD_V_ACTIVE,
    parameter int V_FP       = HD_V_FP,
    parameter int V_SYNC     = HD_V_SYNC,
    parameter int V_BP       = HD_V_BP,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pix_en_in,
    input  logic [7:0]  color_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        active_out,
    output logic        new_frame_out,
    output logic [5:0]  frame_cnt_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic [7:0]  color_out
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 1024 ||
            PIPE_DEPTH < 0 || PIPE_DEPTH > 15) begin : g_bad_cfg
            $error("video_scan_gen: timing does not fit counters");
        end
    endgenerate

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [5:0]  frame_cnt;
    logic        active;
    logic        new_frame;
    sync_t       raw;
    sync_t       dly;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
        end else if (pix_en_in) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
            if (new_frame) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign active    = (hcount < H_VIS) && (vcount < V_VIS);
    assign new_frame = (hcount == H_VIS) && (vcount == V_VIS);

    always_comb begin
        raw    = '0;
        raw.hs = (hcount >= HS_BEG) && (hcount <= HS_END);
        raw.vs = (vcount >= VS_BEG) && (vcount <= VS_END);
        raw.de = active;
    end

    sync_delay #(
        .DEPTH (PIPE_DEPTH),
        .WIDTH ($bits(sync_t))
    ) u_sync_delay (
        .clk   (clk_in),
        .rst_n (rst_in),
        .en    (pix_en_in),
        .d     (raw),
        .q     (dly)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
            color_out <= 8'h00;
        end else if (pix_en_in) begin
            hsync_out <= dly.hs;
            vsync_out <= dly.vs;
            de_out    <= dly.de;
            color_out <= dly.de ? color_in : 8'h00;
        end
    end

    // Held low during reset even though the counters sit at (0,0).
    assign active_out    = active && rst_in;
    assign new_frame_out = new_frame;
    assign hcount_out    = hcount;
    assign vcount_out    = vcount;
    assign frame_cnt_out = frame_cnt;

endmodule
